// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) line arbiter in front of a single-ported memory.
// Latency: gnt + mem_req 1 cycle after req; fill_valid 1 cycle after mem_ack.
// Backpressure: clients hold req until gnt; memory stalls via late mem_ack.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int MAX_D_STREAK = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_fill_valid,
    output logic [LINE_WIDTH-1:0] ic_fill_data,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic                  dc_gnt,
    output logic                  dc_fill_valid,
    output logic [LINE_WIDTH-1:0] dc_fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int OFFS = $clog2(LINE_WIDTH / 8);
    localparam int SW   = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [SW-1:0]         streak;
    logic                  owner_dc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  pick_ic;

    // dcache has priority until it has won MAX_D_STREAK contended rounds in a row
    assign pick_ic = ic_req && (!dc_req || (streak == STREAK_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            streak   <= '0;
            owner_dc <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ic_gnt   <= 1'b0;
            dc_gnt   <= 1'b0;
        end else begin
            ic_gnt <= 1'b0;
            dc_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        state <= BUSY;
                        if (pick_ic) begin
                            owner_dc <= 1'b0;
                            addr_q   <= ic_addr & ADDR_MASK;
                            we_q     <= 1'b0;
                            wdata_q  <= '0;
                            ic_gnt   <= 1'b1;
                            streak   <= '0;
                        end else begin
                            owner_dc <= 1'b1;
                            addr_q   <= dc_addr & ADDR_MASK;
                            we_q     <= dc_we;
                            wdata_q  <= dc_wdata;
                            dc_gnt   <= 1'b1;
                            if (ic_req && (streak != STREAK_MAX))
                                streak <= streak + SW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req       = (state == BUSY);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign ic_fill_valid = (state == RESP) && !owner_dc;
    assign dc_fill_valid = (state == RESP) && owner_dc;
    assign ic_fill_data  = rdata_q;
    assign dc_fill_data  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants,
// a monitor pops them on gnt and checks the memory side and fill response.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_gnt;
    logic         ic_fill_valid;
    logic [127:0] ic_fill_data;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_gnt;
    logic         dc_fill_valid;
    logic [127:0] dc_fill_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    typedef struct {
        bit           dc;
        logic [31:0]  ma;
        bit           we;
        logic [127:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_dly = 3;
    int   stray_req = 0;
    int   ack_cyc = -10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MAX_D_STREAK(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_fill_valid(ic_fill_valid), .ic_fill_data(ic_fill_data),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_fill_valid(dc_fill_valid), .dc_fill_data(dc_fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [127:0] model_rd(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a, a, 32'hC0DE_0000 | {16'h0, a[15:0]}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit dc, input logic [31:0] ma, input bit we,
                                input logic [127:0] wd);
        exp_t e;
        e.dc = dc; e.ma = ma; e.we = we; e.wd = wd;
        return e;
    endfunction

    task automatic responder();
        int cnt = 0;
        int done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                mem_ack = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (stray_req != done) begin
                done++;
                mem_ack = 1'b1;
                mem_rdata = {4{32'hBAD0_BAD0}};
            end else if (mem_req) begin
                cnt++;
                if (cnt == ack_dly + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = model_rd(mem_addr);
                    ack_cyc = cyc;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t cur;
        bit   cur_vld = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_vld = 0;
                continue;
            end
            if (ic_gnt || dc_gnt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", {ic_gnt, dc_gnt}, 2'b00);
                end else begin
                    cur = exp_q.pop_front();
                    cur_vld = 1;
                    chk("gnt_owner", {ic_gnt, dc_gnt}, cur.dc ? 2'b01 : 2'b10);
                end
            end
            if (mem_req) begin
                if (!cur_vld) begin
                    chk("req_without_gnt", mem_req, 1'b0);
                end else begin
                    chk("mem_addr", mem_addr, cur.ma);
                    chk("mem_we", mem_we, cur.we);
                    chk("mem_wdata", mem_wdata, cur.wd);
                end
            end
            if (ic_fill_valid || dc_fill_valid) begin
                if (!cur_vld) begin
                    chk("fill_without_txn", {ic_fill_valid, dc_fill_valid}, 2'b00);
                end else begin
                    chk("fill_owner", {ic_fill_valid, dc_fill_valid}, cur.dc ? 2'b01 : 2'b10);
                    chk("fill_latency", cyc, ack_cyc + 1);
                    chk("fill_data", cur.dc ? dc_fill_data : ic_fill_data, model_rd(cur.ma));
                    chk("resp_mem_req", mem_req, 1'b0);
                    cur_vld = 0;
                end
            end
        end
    endtask

    task automatic wait_gnt(input int n, input string name);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 200) begin
            @(negedge clk);
            t++;
            if (ic_gnt || dc_gnt) seen++;
        end
        if (seen < n) chk({name, "_gnt_timeout"}, seen, n);
    endtask

    task automatic wait_fill(input string name);
        int t = 0;
        bit got = 0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            got = ic_fill_valid || dc_fill_valid;
        end
        if (!got) chk({name, "_fill_timeout"}, got, 1'b1);
    endtask

    task automatic quiet(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({name, "_ctrl"}, {ic_gnt, dc_gnt, ic_fill_valid, dc_fill_valid, mem_req, mem_we}, 6'b0);
            chk({name, "_addr"}, mem_addr, 32'h0);
            chk({name, "_data"}, {ic_fill_data ^ dc_fill_data ^ mem_wdata}, 128'h0);
            chk({name, "_fdata"}, dc_fill_data, 128'h0);
        end
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        fork
            responder();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1);
            end
        join_none

        // reset state
        quiet(2, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // icache-only fill with 3-cycle memory, unaligned address
        ack_dly = 3;
        exp_q.push_back(mk(0, 32'h1000, 0, '0));
        ic_addr = 32'h1004;
        ic_req = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk("ic_gnt_latency", ic_gnt, 1'b1);
        ic_req = 1'b0;
        wait_fill("ic_only");
        chk("ic_fill_cycle", cyc - t0, 5);

        // dcache write-back
        ack_dly = 2;
        exp_q.push_back(mk(1, 32'h2040, 1, {16{8'hA5}}));
        dc_addr = 32'h204C; dc_we = 1'b1; dc_wdata = {16{8'hA5}}; dc_req = 1'b1;
        wait_gnt(1, "wb");
        dc_req = 1'b0;
        wait_fill("wb");

        // both held continuously: D,D,I,D,D,I
        ack_dly = 1;
        dc_we = 1'b0; dc_wdata = {4{32'h1234_5678}};
        dc_addr = 32'h4014; ic_addr = 32'h3008;
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) exp_q.push_back(mk(0, 32'h3000, 0, '0));
            else exp_q.push_back(mk(1, 32'h4010, 0, {4{32'h1234_5678}}));
        end
        ic_req = 1'b1; dc_req = 1'b1;
        wait_gnt(6, "contend");
        ic_req = 1'b0; dc_req = 1'b0;
        wait_fill("contend");

        // streak cleared by a lone icache win; dropped dcache req discarded
        ack_dly = 2;
        exp_q.push_back(mk(1, 32'h5000, 0, {4{32'h1234_5678}}));
        exp_q.push_back(mk(0, 32'h6000, 0, '0));
        exp_q.push_back(mk(1, 32'h5000, 0, {4{32'h1234_5678}}));
        exp_q.push_back(mk(1, 32'h5000, 0, {4{32'h1234_5678}}));
        exp_q.push_back(mk(0, 32'h6000, 0, '0));
        ic_addr = 32'h6000; dc_addr = 32'h5000;
        ic_req = 1'b1; dc_req = 1'b1;
        wait_gnt(1, "streak_d");
        dc_req = 1'b0;
        @(negedge clk);
        dc_addr = 32'h7770; dc_req = 1'b1;
        @(negedge clk);
        dc_req = 1'b0; dc_addr = 32'h5000;
        wait_gnt(1, "streak_i");
        dc_req = 1'b1;
        wait_gnt(3, "streak_after");
        ic_req = 1'b0; dc_req = 1'b0;
        wait_fill("streak_after");

        // reset during BUSY aborts the transaction
        ack_dly = 10;
        exp_q.push_back(mk(1, 32'h8000, 0, {4{32'h1234_5678}}));
        dc_addr = 32'h8000; dc_req = 1'b1;
        wait_gnt(1, "abort");
        dc_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", mem_req, 1'b1);
        rst_n = 1'b0;
        quiet(2, "in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req", mem_req, 1'b0);
        stray_req++;
        quiet(4, "post_reset");

        // mem_ack pulse while idle
        stray_req++;
        quiet(4, "idle_ack");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter LINE_WIDTH, default 128, cache line width in bits.
REQ-003 Parameter MAX_D_STREAK, default 2, max consecutive contended dcache wins before icache is forced.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ic_req  input  1  icache line-fill request, held until ic_gnt.
REQ-007 ic_addr  input  ADDR_WIDTH  icache fill address.
REQ-008 ic_gnt  output  1  one-cycle pulse: icache request accepted.
REQ-009 ic_fill_valid  output  1  one-cycle pulse: ic_fill_data valid.
REQ-010 ic_fill_data  output  LINE_WIDTH  returned icache line.
REQ-011 dc_req  input  1  dcache request (fill or write-back), held until dc_gnt.
REQ-012 dc_we  input  1  1 = write-back, 0 = fill.
REQ-013 dc_addr  input  ADDR_WIDTH  dcache address.
REQ-014 dc_wdata  input  LINE_WIDTH  write-back line.
REQ-015 dc_gnt  output  1  one-cycle pulse: dcache request accepted.
REQ-016 dc_fill_valid  output  1  one-cycle pulse: dcache transaction complete; data valid if fill.
REQ-017 dc_fill_data  output  LINE_WIDTH  returned dcache line.
REQ-018 mem_req  output  1  memory request, held until mem_ack.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  ADDR_WIDTH  line-aligned memory address.
REQ-021 mem_wdata  output  LINE_WIDTH  memory write data.
REQ-022 mem_ack  input  1  one-cycle pulse: memory transaction done.
REQ-023 mem_rdata  input  LINE_WIDTH  read data, valid with mem_ack.

Function
REQ-024 FSM states: IDLE, BUSY, RESP; arbitration occurs only in IDLE.
REQ-025 IDLE with any req high: the winner is chosen, its addr/we/wdata are latched, the FSM moves to BUSY, and the winner's gnt pulses in the first BUSY cycle.
REQ-026 Arbitration priority: dcache wins over icache, unless both request and the streak counter equals MAX_D_STREAK, in which case icache wins.
REQ-027 Streak counter: +1 on a contended dcache win, cleared on any icache win, unchanged on an uncontended dcache win, saturating at MAX_D_STREAK.
REQ-028 An icache transaction always has mem_we = 0; a dcache transaction has mem_we = latched dc_we.
REQ-029 mem_addr = latched address with the low log2(LINE_WIDTH/8) bits forced to 0.
REQ-030 BUSY: mem_req = 1 with stable mem_addr/mem_we/mem_wdata until mem_ack; on mem_ack, mem_rdata is captured and the FSM moves to RESP.
REQ-031 RESP (exactly one cycle): the owner's fill_valid = 1 and fill_data = captured data, mem_req = 0, then the FSM moves to IDLE.
REQ-032 fill_data holds its value until the next capture; the non-owner's fill_valid stays 0.
REQ-033 A write-back also completes with dc_fill_valid; dc_fill_data then carries the captured mem_rdata, which is don't-care to the requester.
REQ-034 Requests are ignored in BUSY/RESP; a req dropped before gnt is discarded with no side effect.
REQ-035 mem_ack in IDLE or RESP is ignored.
REQ-036 Minimum transaction latency: req at cycle T gives gnt and mem_req at T+1; mem_ack at A gives fill_valid at A+1; next arbitration at A+2.

Reset
REQ-037 On rst_n low, asynchronously: FSM = IDLE, streak = 0, all outputs and latched data = 0.
REQ-038 Reset mid-transaction aborts the transaction with no fill_valid; requesters must re-request.
REQ-039 The first arbitration happens on the first rising edge with rst_n high.

Verification
REQ-040 ic_req only, ic_addr=0x1004, mem_ack 3 cycles after mem_req -> ic_gnt at T+1, mem_addr=0x1000, mem_we=0, ic_fill_valid at T+5 with data = mem_rdata.
REQ-041 ic_req and dc_req held continuously, MAX_D_STREAK=2 -> grant order D,D,I,D,D,I.
REQ-042 dc_req with dc_we=1, dc_wdata=0xA5..A5 -> mem_we=1, mem_wdata stable through BUSY, dc_fill_valid one cycle after mem_ack, ic_fill_valid=0.
REQ-043 rst_n low during BUSY, then mem_ack after release -> no fill_valid, mem_req=0, FSM in IDLE.
REQ-044 mem_ack pulse in IDLE with no requests -> no outputs change.
REQ-045 dc_req dropped one cycle before arbitration, ic_req high -> icache granted, streak counter cleared.
